// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory master
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} lsu_size_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_RMW_RD, ST_WR, ST_RESP} lsu_state_e;
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'd0);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                          input logic [1:0] sz, input logic u);
    logic [31:0] s;
    s = w >> {o, 3'b000};
    return sz == SZ_BYTE ? {{24{s[7] & ~u}}, s[7:0]} :
           sz == SZ_HALF ? {{16{s[15] & ~u}}, s[15:0]} : w;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] o, input logic [1:0] sz);
    logic [31:0] m;
    m = (sz == SZ_BYTE ? 32'h0000_00FF : sz == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {o, 3'b000};
    return (old & ~m) | ((wd << {o, 3'b000}) & m);
  endfunction
  assign load_data  = extract(word, off, size, uns);
  assign merge_data = merge(word, wdata, off, size);
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-outstanding load/store master on a word-wide memory port, RMW for sub-word stores
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MEMSIZE   = 32'h10000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  lsu_state_e  state;
  lsu_req_t    req;
  logic [31:0] rdata_q, merge_q, load_data, merge_data, off_addr;
  logic        err_q, bad, mem_act;
  lsu_lane_align u_align (
    .word(mem_rdata_i), .wdata(req.wdata), .off(req.addr[1:0]), .size(req.size),
    .uns(req.uns), .load_data(load_data), .merge_data(merge_data)
  );
  // subtracting first makes addresses below BASE_ADDR wrap into the out-of-range set
  assign off_addr    = req_addr_i - BASE_ADDR;
  assign bad         = req_size_i == 2'd3 || is_misaligned(req_size_i, req_addr_i[1:0]) ||
                       req_addr_i < BASE_ADDR || off_addr >= MEMSIZE;
  assign mem_act     = state == ST_RD || state == ST_RMW_RD || state == ST_WR;
  assign req_ready_o = rst_n_i && state == ST_IDLE;
  assign rsp_valid_o = state == ST_RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_wen_o   = state == ST_WR;
  assign mem_addr_o  = mem_act ? {req.addr[31:2], 2'b00} : BASE_ADDR;
  assign mem_wdata_o = state == ST_WR ? merge_q : '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      req     <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          req     <= '{we: req_we_i, size: req_size_i, uns: req_unsigned_i, addr: req_addr_i, wdata: req_wdata_i};
          rdata_q <= '0;
          merge_q <= req_wdata_i;
          err_q   <= bad;
          state   <= bad ? ST_RESP : !req_we_i ? ST_RD : req_size_i == SZ_WORD ? ST_WR : ST_RMW_RD;
        end
        ST_RD: begin
          rdata_q <= req.we ? '0 : load_data;
          state   <= ST_RESP;
        end
        ST_RMW_RD: begin
          merge_q <= merge_data;
          state   <= ST_WR;
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: if (rsp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: table-driven scoreboard bench with a word memory model and corner-case sequences
module tb_lsu_mem_master;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0, rsp_ready_i = 1'b1;
  logic [1:0]  req_size_i = 2'd0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, mem_wen_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] mem [0:16383];
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          lat, wens;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int n_cmp = 0, n_bad = 0;
  lsu_mem_master dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  assign mem_rdata_i = mem[mem_addr_o[15:2]];
  always @(posedge clk_i) if (mem_wen_o) mem[mem_addr_o[15:2]] <= mem_wdata_o;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err;
    v.lat  = err ? 1 : (we && size != 2'd2) ? 3 : 2;
    v.wens = (!err && we) ? 1 : 0;
    return v;
  endfunction
  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
  endtask
  task automatic do_req(input vec_t v);
    vec_t e;
    int lat, wens;
    logic [31:0] waddr;
    lat = 0; wens = 0; waddr = '0;
    sb.push_back(v);
    @(negedge clk_i);
    chk("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    do begin
      @(negedge clk_i);
      lat++;
      if (mem_wen_o) begin
        wens++;
        waddr = mem_addr_o;
      end
    end while (lat < 10 && !rsp_valid_o);
    e = sb.pop_front();
    chk($sformatf("latency@%h", e.addr), lat, e.lat);
    chk($sformatf("err@%h", e.addr), {31'b0, rsp_err_o}, {31'b0, e.err});
    chk($sformatf("rdata@%h", e.addr), rsp_rdata_o, e.rdata);
    chk($sformatf("wen_cycles@%h", e.addr), wens, e.wens);
    if (e.wens > 0) chk($sformatf("wen_addr@%h", e.addr), waddr, e.addr & ~32'd3);
    chk("req_ready_in_resp", {31'b0, req_ready_o}, 32'd0);
  endtask
  initial begin
    vecs.push_back(mk(1, 2, 0, 32'h100,  32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h100,  0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2, 0, 32'h200,  32'h11223344, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h202,  32'h000000AA, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h200,  0, 32'h11AA3344, 0));
    vecs.push_back(mk(1, 2, 0, 32'h300,  32'h80FF7F01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h301,  0, 32'h0000007F, 0));
    vecs.push_back(mk(0, 0, 0, 32'h302,  0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 0, 1, 32'h303,  0, 32'h00000080, 0));
    vecs.push_back(mk(0, 1, 0, 32'h302,  0, 32'hFFFF80FF, 0));
    vecs.push_back(mk(0, 1, 1, 32'h302,  0, 32'h000080FF, 0));
    vecs.push_back(mk(0, 0, 0, 32'h300,  0, 32'h00000001, 0));
    vecs.push_back(mk(1, 1, 0, 32'h302,  32'h1234BEEF, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h300,  0, 32'hBEEF7F01, 0));
    vecs.push_back(mk(0, 1, 0, 32'h101,  0, 0, 1));
    vecs.push_back(mk(0, 2, 0, 32'h102,  0, 0, 1));
    vecs.push_back(mk(0, 3, 0, 32'h100,  0, 0, 1));
    vecs.push_back(mk(0, 2, 0, 32'h10000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h10000, 32'h55, 0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h201,  32'hFFFF, 0, 1));
    vecs.push_back(mk(0, 2, 0, 32'h200,  0, 32'h11AA3344, 0));
    vecs.push_back(mk(1, 2, 0, 32'hFFFC, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'hFFFC, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF, 0, 32'h000000CA, 0));
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst_mem_wen", {31'b0, mem_wen_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    rst_n_i = 1'b1;
    foreach (vecs[i]) do_req(vecs[i]);
    chk("mem_word_0x200", mem[32'h200 >> 2], 32'h11AA3344);
    @(negedge clk_i);
    chk("idle_mem_wen", {31'b0, mem_wen_o}, 32'd0);
    chk("idle_mem_addr", mem_addr_o, 32'd0);
    chk("idle_mem_wdata", mem_wdata_o, 32'd0);
    // response backpressure: five stalled cycles, then accept resumes after IDLE
    rsp_ready_i = 1'b0;
    drive(0, 2, 0, 32'h300, 0);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("bp_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("bp_rdata", rsp_rdata_o, 32'hBEEF7F01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("bp_hold_rdata", rsp_rdata_o, 32'hBEEF7F01);
      chk("bp_hold_ready", {31'b0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("bp_release_ready", {31'b0, req_ready_o}, 32'd1);
    // abort a byte store by reset during RMW_RD (s=1) and during WR (s=2)
    do_req(mk(1, 2, 0, 32'h400, 32'h55667788, 0, 0));
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk_i);
      drive(1, 0, 0, 32'h401, 32'h99);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      repeat (s - 1) @(posedge clk_i);
      #2 chk("abort_pre_wen", {31'b0, mem_wen_o}, (s == 2) ? 32'd1 : 32'd0);
      rst_n_i = 1'b0;
      #1;
      chk("abort_wen", {31'b0, mem_wen_o}, 32'd0);
      chk("abort_addr", mem_addr_o, 32'd0);
      chk("abort_wdata", mem_wdata_o, 32'd0);
      chk("abort_ready", {31'b0, req_ready_o}, 32'd0);
      chk("abort_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      chk("abort_mem_word", mem[32'h400 >> 2], 32'h55667788);
    end
    do_req(mk(0, 2, 0, 32'h400, 0, 32'h55667788, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
